// File: rtl/p_int_mac_acc_if.sv
// Handshake and data bundle for the perceptron MAC stage.
// Input side : in_valid/in_ready/in_last with x (activation) and w (weight).
// Output side: out_valid/out_ready with out (saturated sum), ovf (sticky
//              saturation flag) and cnt (beats accumulated in the vector).
// Modports   : slave  - the MAC stage itself
//              master - whoever feeds beats and drains results
interface p_int_mac_acc_if #(
    parameter int X_PREC   = 8,
    parameter int W_PREC   = 8,
    parameter int O_PREC   = 16,
    parameter int CNT_PREC = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_last;
    logic signed [X_PREC-1:0]   x;
    logic signed [W_PREC-1:0]   w;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [O_PREC-1:0]   out;
    logic                       ovf;
    logic [CNT_PREC-1:0]        cnt;

    modport slave (
        input  in_valid, in_last, x, w, out_ready,
        output in_ready, out_valid, out, ovf, cnt
    );

    modport master (
        output in_valid, in_last, x, w, out_ready,
        input  in_ready, out_valid, out, ovf, cnt
    );
endinterface

// File: rtl/p_int_mac_acc.sv
// Sequential signed multiply-accumulate stage producing the perceptron
// weighted sum sum(x[i]*w[i]) over a vector of beats terminated by in_last.
// The running sum is clamped to O_PREC signed bits after every beat; ovf is
// sticky for the vector once any beat clamped.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - p_int_mac_acc_if.slave (beat input and result output handshakes)
// After the last beat the result is held (in_ready=0, out_valid=1) until
// out_ready; the following cycle the stage is cleared and accepts beats again.
module p_int_mac_acc #(
    parameter int X_PREC   = 8,
    parameter int W_PREC   = 8,
    parameter int O_PREC   = 16,
    parameter int CNT_PREC = 8
) (
    input  logic               clk,
    input  logic               reset,
    p_int_mac_acc_if.slave     bus
);
    localparam int P_PREC = X_PREC + W_PREC;
    // One guard bit above the wider of acc/prod so acc+prod never wraps.
    localparam int S_PREC = ((O_PREC > P_PREC) ? O_PREC : P_PREC) + 1;

    localparam logic signed [S_PREC-1:0] SAT_MAX =
        {{(S_PREC-O_PREC+1){1'b0}}, {(O_PREC-1){1'b1}}};
    localparam logic signed [S_PREC-1:0] SAT_MIN =
        {{(S_PREC-O_PREC+1){1'b1}}, {(O_PREC-1){1'b0}}};

    typedef enum logic {ACC, OUT} state_t;

    state_t                   state;
    logic signed [O_PREC-1:0] acc;
    logic                     ovf_q;
    logic [CNT_PREC-1:0]      cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;

    logic signed [P_PREC-1:0] prod;
    logic signed [S_PREC-1:0] acc_ext;
    logic signed [S_PREC-1:0] prod_ext;
    logic signed [S_PREC-1:0] sum;
    logic signed [S_PREC-1:0] sat_sum;
    logic                     clip;

    // Operands widened to the full product width before multiplying.
    assign prod     = P_PREC'(bus.x) * P_PREC'(bus.w);
    assign acc_ext  = acc;
    assign prod_ext = prod;
    assign sum      = acc_ext + prod_ext;

    always_comb begin
        sat_sum = sum;
        clip    = 1'b0;
        if (sum > SAT_MAX) begin
            sat_sum = SAT_MAX;
            clip    = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_sum = SAT_MIN;
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACC;
            acc         <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (bus.in_valid) begin
                        acc   <= sat_sum[O_PREC-1:0];
                        ovf_q <= ovf_q | clip;
                        // Beat count sticks at all-ones instead of wrapping.
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + CNT_PREC'(1);
                        if (bus.in_last) begin
                            state       <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    // Result held; beat inputs are ignored until retired.
                    if (bus.out_ready) begin
                        state       <= ACC;
                        acc         <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // out follows acc directly: it shows the running sum while accumulating.
    assign bus.out       = acc;
    assign bus.ovf       = ovf_q;
    assign bus.cnt       = cnt_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_p_int_mac_acc.sv
module tb_p_int_mac_acc;
    localparam int X_PREC   = 8;
    localparam int W_PREC   = 8;
    localparam int O_PREC   = 16;
    localparam int CNT_PREC = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    p_int_mac_acc_if #(.X_PREC(X_PREC), .W_PREC(W_PREC), .O_PREC(O_PREC),
                       .CNT_PREC(CNT_PREC)) bus ();

    p_int_mac_acc #(.X_PREC(X_PREC), .W_PREC(W_PREC), .O_PREC(O_PREC),
                    .CNT_PREC(CNT_PREC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        longint out;
        longint ovf;
        longint cnt;
    } res_t;

    res_t   sb[$];
    int     checks = 0;
    int     errors = 0;

    // Reference accumulator (plain integer arithmetic).
    longint m_acc = 0;
    longint m_ovf = 0;
    longint m_cnt = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0; m_ovf = 0; m_cnt = 0;
    endtask

    // Drive one beat starting at a negedge; returns at the next negedge.
    task automatic beat(input int xv, input int wv, input bit last);
        longint s;
        longint lim_hi;
        longint lim_lo;
        lim_hi = (64'sd1 <<< (O_PREC-1)) - 1;
        lim_lo = -(64'sd1 <<< (O_PREC-1));
        bus.x        = X_PREC'(xv);
        bus.w        = W_PREC'(wv);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        if (bus.in_ready === 1'b1) begin
            s = m_acc + longint'(xv) * longint'(wv);
            if (s > lim_hi) begin m_acc = lim_hi; m_ovf = 1; end
            else if (s < lim_lo) begin m_acc = lim_lo; m_ovf = 1; end
            else m_acc = s;
            if (m_cnt < 255) m_cnt++;
            if (last) begin
                sb.push_back('{m_acc, m_ovf, m_cnt});
                model_clear();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.x        = 8'sd50;
        bus.w        = 8'sd50;
        bus.in_last  = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        idle();
        model_clear();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_cnt", bus.cnt, 0);
    endtask

    // Called right after the last beat: result must already be valid.
    task automatic check_result(input string tag);
        res_t e;
        int   n;
        chk({tag, "_latency"}, bus.out_valid, 1);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_out"}, bus.out, e.out);
            chk({tag, "_ovf"}, bus.ovf, e.ovf);
            chk({tag, "_cnt"}, bus.cnt, e.cnt);
            chk({tag, "_in_ready"}, bus.in_ready, 0);
        end
    endtask

    task automatic retire(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ret_in_ready"}, bus.in_ready, 1);
        chk({tag, "_ret_out_valid"}, bus.out_valid, 0);
        chk({tag, "_ret_cnt"}, bus.cnt, 0);
        chk({tag, "_ret_ovf"}, bus.ovf, 0);
    endtask

    initial begin
        logic signed [O_PREC-1:0] h_out;
        logic                     h_ovf;
        logic [CNT_PREC-1:0]      h_cnt;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.x         = '0;
        bus.w         = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset held with in_valid high: nothing may accumulate.
        do_reset(2);
        @(negedge clk);
        chk("idle_out", bus.out, 0);

        // Normal vector.
        beat(3, 4, 0);
        beat(-2, 5, 0);
        beat(10, -1, 1);
        idle();
        chk("norm_out_const", bus.out, -8);
        check_result("norm");
        retire("norm");

        // Positive saturation.
        beat(127, 127, 0);
        chk("pos_run1", bus.out, 16129);
        beat(127, 127, 0);
        chk("pos_run2", bus.out, 32258);
        beat(127, 127, 1);
        idle();
        chk("pos_out_const", bus.out, 32767);
        check_result("pos");
        retire("pos");

        // Positive saturation then pulled back off the rail.
        beat(127, 127, 0);
        beat(127, 127, 0);
        beat(127, 127, 0);
        beat(-128, 127, 1);
        idle();
        chk("back_out_const", bus.out, 16511);
        chk("back_ovf_const", bus.ovf, 1);
        check_result("back");
        retire("back");

        // Negative saturation.
        beat(-128, 127, 0);
        beat(-128, 127, 0);
        beat(-128, 127, 1);
        idle();
        chk("neg_out_const", bus.out, -32768);
        check_result("neg");

        // Backpressure: result held while beat inputs toggle.
        h_out = bus.out;
        h_ovf = bus.ovf;
        h_cnt = bus.cnt;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = $urandom_range(0, 1);
            bus.in_last  = $urandom_range(0, 1);
            bus.x        = X_PREC'($urandom);
            bus.w        = W_PREC'($urandom);
            @(negedge clk);
            chk("bp_out", bus.out, h_out);
            chk("bp_ovf", bus.ovf, h_ovf);
            chk("bp_cnt", bus.cnt, h_cnt);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        idle();
        retire("bp");
        beat(2, 3, 1);
        idle();
        check_result("after_bp");
        retire("after_bp");

        // Single-cycle in_last without in_valid does nothing.
        bus.in_last = 1'b1;
        @(negedge clk);
        bus.in_last = 1'b0;
        chk("last_no_valid", bus.out_valid, 0);

        // Reset mid-vector discards the partial sum.
        beat(100, 100, 0);
        beat(50, 50, 0);
        chk("mid_run_out", bus.out, 12500);
        chk("mid_run_cnt", bus.cnt, 2);
        idle();
        do_reset(1);
        beat(2, 3, 1);
        idle();
        chk("mid_out_const", bus.out, 6);
        check_result("mid");

        // Reset while holding a result.
        do_reset(1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/p_int_mac_acc.md
Name: p_int_mac_acc

Overview:
- Sequential signed multiply-accumulate stage that computes the perceptron weighted sum, sum(x[i]*w[i]), from a stream of input/weight pairs.
- Sits directly upstream of the saturating integer subtractor, which consumes the accumulated sum (e.g. sum minus threshold/bias).
- Result is saturated to O_PREC signed bits, with a sticky overflow flag; the output width and flag semantics match the subtractor's ovf/out convention.

Parameters:
- X_PREC, 8, input activation width (signed two's complement)
- W_PREC, 8, weight width (signed two's complement)
- O_PREC, 16, accumulator/result width (signed); O_PREC >= 2
- CNT_PREC, 8, beat counter width

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage accepts a beat
- in_last  input  1  marks final beat of a vector
- x  input  X_PREC  activation, signed
- w  input  W_PREC  weight, signed
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  O_PREC  saturated weighted sum, signed
- ovf  output  1  saturation occurred on any beat of this vector
- cnt  output  CNT_PREC  number of beats accumulated in this vector

Behaviour:
- One clock; reset is synchronous and active-high; clock is clk, reset is reset.
- Reset: state=ACC; acc=0; ovf=0; cnt=0; out_valid=0; out=0. Reset wins over every other event, including mid-vector and while holding a result; any partial sum is discarded.
- States:
  - ACC: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Beat accepted when state=ACC and in_valid=1. On an accepted beat:
  - prod = signed(x)*signed(w), full X_PREC+W_PREC bits.
  - sum = acc + prod, computed at width max(O_PREC, X_PREC+W_PREC)+1 with no internal wrap.
  - sat: sum > 2^(O_PREC-1)-1 gives 2^(O_PREC-1)-1; sum < -2^(O_PREC-1) gives -2^(O_PREC-1); otherwise sum.
  - acc <= sat(sum); ovf <= ovf | (sum != sat(sum)).
  - cnt <= cnt+1, saturating at all-ones; no wrap.
- Saturation is applied per step. A later beat of opposite sign moves acc back off the rail, but ovf stays 1 until the vector is retired.
- Accepted beat with in_last=1: transition ACC->OUT. out/ovf/cnt reflect that beat's contribution; out_valid=1 on the next cycle (latency 1 cycle from last beat).
- In OUT: out, ovf, cnt are held stable. x/w/in_valid/in_last are ignored.
- On out_valid && out_ready: next cycle state=ACC, acc=0, ovf=0, cnt=0, out_valid=0. One bubble cycle is inherent; in_ready=!out_valid with no combinational path from out_ready.
- out is driven from acc directly, so out shows the running sum in ACC. Downstream samples out only when out_valid=1.
- in_last with in_valid=0 has no effect.
- A zero-length vector is impossible; a vector always contains at least one beat.

Test Plan:
- Reset: assert reset 2 cycles -> in_ready=1, out_valid=0, out=0, ovf=0, cnt=0. Reset held with in_valid=1 -> nothing accumulated.
- Normal (X=W=8, O=16): beats (3,4), (-2,5), (10,-1, last) back-to-back -> one cycle after last: out_valid=1, out=-8, ovf=0, cnt=3, in_ready=0.
- Positive saturation: beats (127,127) x3, last on 3rd -> acc 16129, then 32258, then clamped 32767; out=32767, ovf=1, cnt=3. Variant: 4th beat (-128,127) before last -> out=16511, ovf still 1.
- Negative saturation: beats (-128,127) x3 -> -16256, -32512, then clamped -32768; out=-32768, ovf=1.
- Backpressure: after result, hold out_ready=0 for 5 cycles while toggling x/w/in_valid -> out/ovf/cnt stable, in_ready=0. Then out_ready=1 for 1 cycle -> next cycle in_ready=1. Next vector (2,3, last) -> out=6, ovf=0, cnt=1.
- Reset mid-vector: beats (100,100), (50,50), then reset -> state cleared. Then (2,3, last) -> out=6, cnt=1, ovf=0.
